// File: rtl/canvas_plotter.sv
// canvas_plotter: turns draw/erase decisions into single-pixel VGA writes
//   clk, reset (sync, active-low)
//   draw, erase             level requests from the drawing controller
//   color, mouse_x, mouse_y brush colour and cursor position
//   vga_x, vga_y, vga_colour, vga_plot  registered pixel write port
//   busy                    high while a stamp or sweep is in progress
// Define CANVAS_PLOTTER_DEDUP_EN to skip re-stamping an unchanged brush.
module canvas_plotter #(
    parameter int          CANVAS_W    = 160,
    parameter int          CANVAS_H    = 120,
    parameter int          XW          = 8,
    parameter int          YW          = 7,
    parameter int          BRUSH       = 3,
    parameter logic [14:0] ERASE_COLOR = 15'h7FFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          draw,
    input  logic          erase,
    input  logic [14:0]   color,
    input  logic [XW-1:0] mouse_x,
    input  logic [YW-1:0] mouse_y,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [14:0]   vga_colour,
    output logic          vga_plot,
    output logic          busy
);
    localparam int R  = BRUSH / 2;
    localparam int BW = $clog2(BRUSH + 1);

    typedef enum logic [1:0] {IDLE, STAMP, SWEEP} state_t;
    state_t state_q, state_d;

    logic [BW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [XW-1:0] cx_q, cx_d, bx_q, bx_d, x_q, x_d;
    logic [YW-1:0] cy_q, cy_d, by_q, by_d, y_q, y_d;
    logic [14:0]   bcol_q, bcol_d, col_q, col_d;
    logic          armed_q, armed_d, plot_q, plot_d, busy_q, busy_d;
    logic          dup, start_sweep, start_stamp, in_rng;
    logic [XW:0]   px;
    logic [YW:0]   py;

    // The last latched brush doubles as the dedup reference.
`ifdef CANVAS_PLOTTER_DEDUP_EN
    logic valid_q;
    assign dup = valid_q && mouse_x == bx_q && mouse_y == by_q && color == bcol_q;
    always_ff @(posedge clk)
        if (!reset) valid_q <= 1'b0;
        else        valid_q <= start_sweep ? 1'b0 : start_stamp ? 1'b1 : valid_q;
`else
    assign dup = 1'b0;
`endif

    assign start_sweep = state_q == IDLE && erase && armed_q;
    assign start_stamp = state_q == IDLE && draw && !erase && !dup;

    // One extra bit so positions left of / above the canvas read as negative.
    assign px     = {1'b0, bx_q} + (XW+1)'(ox_q) - (XW+1)'(R);
    assign py     = {1'b0, by_q} + (YW+1)'(oy_q) - (YW+1)'(R);
    assign in_rng = !px[XW] && px < (XW+1)'(CANVAS_W) && !py[YW] && py < (YW+1)'(CANVAS_H);

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bcol_d  = bcol_q;
        armed_d = armed_q | ~erase;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_sweep) begin
                    state_d = SWEEP;
                    armed_d = 1'b0;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (start_stamp) begin
                    state_d = STAMP;
                    bx_d    = mouse_x;
                    by_d    = mouse_y;
                    bcol_d  = color;
                    ox_d    = '0;
                    oy_d    = '0;
                end
            end
            STAMP: begin
                busy_d  = 1'b1;
                plot_d  = in_rng;
                x_d     = in_rng ? px[XW-1:0] : x_q;
                y_d     = in_rng ? py[YW-1:0] : y_q;
                col_d   = in_rng ? bcol_q : col_q;
                ox_d    = ox_q == BW'(BRUSH-1) ? '0 : ox_q + 1'b1;
                oy_d    = ox_q == BW'(BRUSH-1) ? oy_q + 1'b1 : oy_q;
                state_d = ox_q == BW'(BRUSH-1) && oy_q == BW'(BRUSH-1) ? IDLE : STAMP;
            end
            SWEEP: begin
                busy_d  = 1'b1;
                plot_d  = 1'b1;
                x_d     = cx_q;
                y_d     = cy_q;
                col_d   = ERASE_COLOR;
                cx_d    = cx_q == XW'(CANVAS_W-1) ? '0 : cx_q + 1'b1;
                cy_d    = cx_q == XW'(CANVAS_W-1) ? cy_q + 1'b1 : cy_q;
                state_d = cx_q == XW'(CANVAS_W-1) && cy_q == YW'(CANVAS_H-1) ? IDLE : SWEEP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bcol_q  <= '0;
            armed_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bcol_q  <= bcol_d;
            armed_q <= armed_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = col_q;
    assign vga_plot   = plot_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_canvas_plotter.sv
// tb_canvas_plotter: directed checks of canvas_plotter stamps, sweeps, reset and dedup
module tb_canvas_plotter;
    logic        clk = 1'b0, reset = 1'b0, draw = 1'b0, erase = 1'b0;
    logic [14:0] color = '0;
    logic [7:0]  mouse_x = '0;
    logic [6:0]  mouse_y = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [14:0] vga_colour;
    logic        vga_plot, busy;

    canvas_plotter dut (
        .clk(clk), .reset(reset), .draw(draw), .erase(erase), .color(color),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int col; int cyc;} pix_t;
    pix_t q[$];
    int   cyc = 0, busy_cnt = 0, n_chk = 0, n_pass = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (vga_plot) q.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour), cyc});
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] pk(input int x, input int y, input int c);
        return {2'b0, x[7:0], y[6:0], c[14:0]};
    endfunction

    function automatic logic [31:0] at(input int i);
        return i < q.size() ? pk(q[i].x, q[i].y, q[i].col) : '1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        q.delete();
        busy_cnt = 0;
    endtask

    task automatic pulse(input int x, input int y, input int c);
        mouse_x = x[7:0];
        mouse_y = y[6:0];
        color   = c[14:0];
        draw    = 1'b1;
        tick(1);
        draw    = 1'b0;
    endtask

    function automatic int sweep_errs();
        int e = 0;
        for (int i = 0; i < q.size(); i++)
            if (at(i) != pk(i % 160, i / 160, 15'h7FFF)) e++;
        return e;
    endfunction

    int cx[4] = '{0, 1, 0, 1};
    int cy[4] = '{0, 0, 1, 1};

    initial begin
        tick(3);
        chk("rst_plot", vga_plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xyc", pk(vga_x, vga_y, vga_colour), 0);
        reset = 1'b1;
        tick(2);

        clr();
        pulse(50, 40, 15'h001F);
        tick(12);
        chk("int_n", q.size(), 9);
        chk("int_busy", busy_cnt, 9);
        for (int i = 0; i < 9; i++) chk($sformatf("int_px%0d", i), at(i), pk(49 + i % 3, 39 + i / 3, 15'h001F));
        chk("int_span", q.size() == 9 ? q[8].cyc - q[0].cyc : -1, 8);
        chk("int_idle", {vga_plot, busy}, 0);

        clr();
        pulse(0, 0, 15'h7C00);
        tick(12);
        chk("cor_n", q.size(), 4);
        chk("cor_busy", busy_cnt, 9);
        for (int i = 0; i < 4; i++) chk($sformatf("cor_px%0d", i), at(i), pk(cx[i], cy[i], 15'h7C00));

        clr();
        erase = 1'b1;
        tick(20000);
        chk("sw1_n", q.size(), 19200);
        chk("sw1_busy", busy_cnt, 19200);
        chk("sw1_last", at(19199), pk(159, 119, 15'h7FFF));
        chk("sw1_seq", sweep_errs(), 0);
        erase = 1'b0;
        tick(3);
        clr();
        erase = 1'b1;
        tick(2);
        erase = 1'b0;
        tick(19210);
        chk("sw2_n", q.size(), 19200);
        chk("sw2_seq", sweep_errs(), 0);

        clr();
        pulse(80, 60, 15'h03E0);
        tick(3);
        erase = 1'b1;
        for (int i = 0; i < 400 && q.size() < 109; i++) tick(1);
        chk("es_reach", q.size(), 109);
        for (int i = 0; i < 9; i++) chk($sformatf("es_px%0d", i), at(i), pk(79 + i % 3, 59 + i / 3, 15'h03E0));
        chk("es_sw0", at(9), pk(0, 0, 15'h7FFF));
        chk("es_gap", q.size() > 9 ? q[9].cyc - q[8].cyc : -1, 2);
        chk("es_sw99", at(108), pk(99, 0, 15'h7FFF));
        reset = 1'b0;
        tick(1);
        chk("mr_plotbusy", {vga_plot, busy}, 0);
        chk("mr_xyc", pk(vga_x, vga_y, vga_colour), 0);
        chk("mr_n", q.size(), 109);
        erase = 1'b0;
        reset = 1'b1;
        tick(20);
        chk("mr_quiet", q.size(), 109);
        chk("mr_busy", busy, 0);

        clr();
        mouse_x = 8'd30;
        mouse_y = 7'd30;
        color   = 15'h1234;
        draw    = 1'b1;
        tick(40);
        draw    = 1'b0;
        tick(15);
        chk("dd_first", at(0), pk(29, 29, 15'h1234));
`ifdef CANVAS_PLOTTER_DEDUP_EN
        chk("dd_n", q.size(), 9);
`else
        chk("dd_n", q.size(), 36);
        chk("dd_busy", busy_cnt, 36);
        chk("dd_gap", q.size() > 9 ? q[9].cyc - q[8].cyc : -1, 2);
`endif
        clr();
        pulse(31, 30, 15'h1234);
        tick(12);
        chk("mv_n", q.size(), 9);
        chk("mv_first", at(0), pk(30, 29, 15'h1234));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
